// File: rtl/gpu_console_writer.sv
// Console writer: turns an ASCII byte stream into 64-bit cell writes to the GPU framebuffer,
// tracks a 40x30 cursor, and kicks/polls the GPU external->internal copy.
module gpu_console_writer #(
  parameter logic [7:0]  GPU_ADDRESS  = 8'h02,
  parameter logic [10:0] CHAR_BASE    = 11'd4,
  parameter int unsigned COLS         = 40,
  parameter int unsigned ROWS         = 30,
  parameter logic [63:0] CONTROL_WORD = 64'h0
) (
  input  logic        procClock,
  input  logic        resetN,
  input  logic [7:0]  charData,
  input  logic [11:0] charColour,
  input  logic        charValid,
  output logic        charReady,
  input  logic        presentReq,
  output logic        presentDone,
  input  logic        busGrant,
  output logic [63:0] busAddress,
  output logic [63:0] busDataOut,
  input  logic [63:0] busDataIn,
  output logic        busWrite,
  output logic        busRead,
  output logic [5:0]  cursorCol,
  output logic [4:0]  cursorRow
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StPut    = 3'd1;
  localparam logic [2:0] StClrRow = 3'd2;
  localparam logic [2:0] StClrAll = 3'd3;
  localparam logic [2:0] StPWrite = 3'd4;
  localparam logic [2:0] StPPoll  = 3'd5;

  localparam logic [63:0] Blank = 64'h20;

  logic [2:0]  state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [10:0] cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic        done_q, done_d;
  logic        live_q;
  logic [4:0]  row_inc;

  function automatic logic [10:0] cell_off(logic [4:0] r, logic [5:0] c);
    return CHAR_BASE + 11'(r) * 11'(COLS) + 11'(c);
  endfunction

  function automatic logic [63:0] bus_addr(logic [10:0] off);
    return {GPU_ADDRESS, 45'b0, off};
  endfunction

  assign row_inc = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (live_q) begin
          if (presentReq) begin
            state_d = StPWrite;
            addr_d  = bus_addr(11'd0);
            data_d  = CONTROL_WORD | 64'h1;
          end else if (charValid) begin
            if (charData >= 8'h20 && charData <= 8'h7E) begin
              state_d = StPut;
              addr_d  = bus_addr(cell_off(row_q, col_q));
              data_d  = {44'b0, charColour, charData};
            end else if (charData == 8'h0A) begin
              state_d = StClrRow;
              col_d   = '0;
              row_d   = row_inc;
              cnt_d   = '0;
              addr_d  = bus_addr(cell_off(row_inc, 6'd0));
              data_d  = Blank;
            end else if (charData == 8'h0D) begin
              col_d = '0;
            end else if (charData == 8'h0C) begin
              state_d = StClrAll;
              col_d   = '0;
              row_d   = '0;
              cnt_d   = '0;
              addr_d  = bus_addr(CHAR_BASE);
              data_d  = Blank;
            end
          end
        end
      end
      StPut: begin
        if (busGrant) begin
          if (col_q == 6'(COLS - 1)) begin
            state_d = StClrRow;
            col_d   = '0;
            row_d   = row_inc;
            cnt_d   = '0;
            addr_d  = bus_addr(cell_off(row_inc, 6'd0));
            data_d  = Blank;
          end else begin
            state_d = StIdle;
            col_d   = col_q + 6'd1;
          end
        end
      end
      StClrRow, StClrAll: begin
        if (busGrant) begin
          cnt_d  = cnt_q + 11'd1;
          addr_d = bus_addr(addr_q[10:0] + 11'd1);
          if ((state_q == StClrRow && cnt_q == 11'(COLS - 1)) ||
              (state_q == StClrAll && cnt_q == 11'(COLS * ROWS - 1))) begin
            state_d = StIdle;
          end
        end
      end
      StPWrite: begin
        if (busGrant) state_d = StPPoll;
      end
      StPPoll: begin
        if (busGrant && !busDataIn[0]) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge procClock or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      live_q  <= 1'b1;
    end
  end

  // live_q keeps charReady low through the first cycle after reset release.
  assign charReady   = live_q && (state_q == StIdle) && !presentReq;
  assign busWrite    = busGrant && (state_q == StPut || state_q == StClrRow ||
                                    state_q == StClrAll || state_q == StPWrite);
  assign busRead     = busGrant && (state_q == StPPoll);
  assign busAddress  = addr_q;
  assign busDataOut  = data_q;
  assign presentDone = done_q;
  assign cursorCol   = col_q;
  assign cursorRow   = row_q;

endmodule

// File: tb/tb_gpu_console_writer.sv
// Bench for gpu_console_writer: a cursor/framebuffer reference model predicts every bus write,
// and a small GPU model answers control-register polls.
module tb_gpu_console_writer;

  logic        procClock = 1'b0;
  logic        resetN;
  logic [7:0]  charData;
  logic [11:0] charColour;
  logic        charValid;
  logic        charReady;
  logic        presentReq;
  logic        presentDone;
  logic        busGrant;
  logic [63:0] busAddress;
  logic [63:0] busDataOut;
  logic [63:0] busDataIn;
  logic        busWrite;
  logic        busRead;
  logic [5:0]  cursorCol;
  logic [4:0]  cursorRow;

  gpu_console_writer dut (
    .procClock  (procClock),
    .resetN     (resetN),
    .charData   (charData),
    .charColour (charColour),
    .charValid  (charValid),
    .charReady  (charReady),
    .presentReq (presentReq),
    .presentDone(presentDone),
    .busGrant   (busGrant),
    .busAddress (busAddress),
    .busDataOut (busDataOut),
    .busDataIn  (busDataIn),
    .busWrite   (busWrite),
    .busRead    (busRead),
    .cursorCol  (cursorCol),
    .cursorRow  (cursorRow)
  );

  always #5 procClock = ~procClock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] wa_q[$], wd_q[$], ea[$], ed[$];
  int reads, dones, strobe_viol, busy_granted;
  int grant_mode, poll_left;
  bit rd_seen;
  int m_col, m_row;

  assign busDataIn = {63'b0, poll_left != 0};

  // Inputs change 1 time unit after the active edge.
  always @(posedge procClock) begin
    #1;
    if (rd_seen && poll_left > 0) poll_left--;
    rd_seen = 1'b0;
    case (grant_mode)
      0:       busGrant = 1'b1;
      1:       busGrant = ~busGrant;
      default: busGrant = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge procClock) begin
    if (resetN) begin
      if (busWrite) begin
        wa_q.push_back(busAddress);
        wd_q.push_back(busDataOut);
      end
      if (busRead) reads++;
      rd_seen = busRead;
      if (presentDone) dones++;
      if (!busGrant && (busWrite || busRead)) strobe_viol++;
      if (busGrant && !charReady) busy_granted++;
    end
  end

  function automatic logic [63:0] cell_addr(int off);
    return {8'h02, 45'b0, off[10:0]};
  endfunction

  function automatic void push_exp(int off, logic [63:0] d);
    ea.push_back(cell_addr(off));
    ed.push_back(d);
  endfunction

  function automatic void model_char(logic [7:0] c, logic [11:0] colour);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_exp(4 + m_row * 40 + m_col, {44'b0, colour, c});
      m_col++;
      if (m_col == 40) begin
        m_col = 0;
        m_row = (m_row + 1) % 30;
        for (int i = 0; i < 40; i++) push_exp(4 + m_row * 40 + i, 64'h20);
      end
    end else if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 30;
      for (int i = 0; i < 40; i++) push_exp(4 + m_row * 40 + i, 64'h20);
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h0C) begin
      for (int i = 0; i < 1200; i++) push_exp(4 + i, 64'h20);
      m_col = 0;
      m_row = 0;
    end
  endfunction

  // Counts disagreements between logged and predicted writes, then empties both logs.
  function automatic int diff_writes();
    int bad = 0;
    if (wa_q.size() != ea.size()) bad = 1;
    else
      for (int i = 0; i < wa_q.size(); i++)
        if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) bad++;
    wa_q.delete(); wd_q.delete(); ea.delete(); ed.delete();
    return bad;
  endfunction

  task automatic send_char(input logic [7:0] c, input logic [11:0] colour);
    bit ok = 1'b0;
    charData   = c;
    charColour = colour;
    charValid  = 1'b1;
    model_char(c, colour);
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge procClock);
      if (charReady) ok = 1'b1;
      @(posedge procClock);
      #1;
    end
    charValid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_char timeout: byte %h not accepted, required accept within 5000 cycles", c);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge procClock);
      if (charReady) ok = 1'b1;
    end
    @(posedge procClock);
    #1;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s idle timeout: charReady never returned, required within 5000 cycles", name);
    end
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    n_tests++;
    if (cursorCol !== 6'(col) || cursorRow !== 5'(row)) begin
      n_fail++;
      $display("FAIL %s cursor: got (%0d,%0d) required (%0d,%0d)", name, cursorCol, cursorRow,
               col, row);
    end
  endtask

  task automatic check_writes(input string name);
    int got = wa_q.size();
    int exp = ea.size();
    int bad = diff_writes();
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s writes: %0d bad (got %0d writes, required %0d)", name, bad, got, exp);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(posedge procClock);
    #1;
    n_tests++;
    if ({busWrite, busRead, presentDone, charReady, busAddress, busDataOut, cursorCol,
         cursorRow} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got addr=%h data=%h wr=%b rd=%b rdy=%b, required all zero",
               busAddress, busDataOut, busWrite, busRead, charReady);
    end
    resetN = 1'b1;
    @(posedge procClock);
    #1;
    n_tests++;
    if (charReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset charReady: got %b required 1 one cycle after release", charReady);
    end
    check_cursor("reset", 0, 0);
  endtask

  task automatic test_put_char();
    send_char(8'h41, 12'hF00);
    wait_idle("put_char");
    n_tests++;
    if (wa_q.size() < 1 || wa_q[0] !== 64'h0200_0000_0000_0004 || wd_q[0] !== 64'hF0041) begin
      n_fail++;
      $display("FAIL put_char first write: got %0d writes, required addr 0200000000000004 data f0041",
               wa_q.size());
    end
    check_writes("put_char");
    check_cursor("put_char", 1, 0);
  endtask

  task automatic test_wrap_row();
    send_char(8'h0D, 12'h0);
    for (int i = 0; i < 5; i++) send_char(8'h0A, 12'h0);
    for (int i = 0; i < 39; i++) send_char(8'($urandom_range(8'h21, 8'h7E)), 12'($urandom));
    wait_idle("wrap_setup");
    check_writes("wrap_setup");
    check_cursor("wrap_setup", 39, 5);
    send_char(8'h5A, 12'h0F0);
    wait_idle("wrap_row");
    n_tests++;
    if (wa_q.size() !== 41 || wa_q[0] !== cell_addr(243) || wa_q[40] !== cell_addr(283)) begin
      n_fail++;
      $display("FAIL wrap_row shape: got %0d writes, required 41 (offset 243 then 244..283)",
               wa_q.size());
    end
    check_writes("wrap_row");
    check_cursor("wrap_row", 0, 6);
  endtask

  task automatic test_lf_wrap();
    for (int i = 0; i < 23; i++) send_char(8'h0A, 12'h0);
    for (int i = 0; i < 7; i++) send_char(8'($urandom_range(8'h20, 8'h7E)), 12'($urandom));
    wait_idle("lf_setup");
    check_writes("lf_setup");
    check_cursor("lf_setup", 7, 29);
    busy_granted = 0;
    send_char(8'h0A, 12'h0);
    wait_idle("lf_wrap");
    n_tests++;
    if (busy_granted !== 40) begin
      n_fail++;
      $display("FAIL lf_wrap busy: charReady low for %0d granted cycles, required 40", busy_granted);
    end
    check_writes("lf_wrap");
    check_cursor("lf_wrap", 0, 0);
  endtask

  task automatic test_clear_all();
    grant_mode  = 1;
    strobe_viol = 0;
    send_char(8'h41, 12'h00F);
    send_char(8'h0C, 12'h0);
    wait_idle("clear_all");
    n_tests++;
    if (wa_q.size() !== 1201) begin
      n_fail++;
      $display("FAIL clear_all count: got %0d writes, required 1201", wa_q.size());
    end
    check_writes("clear_all");
    check_cursor("clear_all", 0, 0);
    n_tests++;
    if (strobe_viol !== 0) begin
      n_fail++;
      $display("FAIL clear_all grant: %0d strobes without grant, required 0", strobe_viol);
    end
    grant_mode = 0;
  endtask

  task automatic test_random();
    logic [7:0] c;
    grant_mode  = 2;
    strobe_viol = 0;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       c = 8'h0A;
        1:       c = 8'h0D;
        2:       c = 8'($urandom_range(0, 8'h1F));
        3:       c = 8'h7F;
        default: c = 8'($urandom_range(8'h20, 8'h7E));
      endcase
      if (c == 8'h0C) c = 8'h01;
      send_char(c, 12'($urandom));
    end
    wait_idle("random");
    check_writes("random");
    check_cursor("random", m_col, m_row);
    n_tests++;
    if (strobe_viol !== 0) begin
      n_fail++;
      $display("FAIL random grant: %0d strobes without grant, required 0", strobe_viol);
    end
    grant_mode = 0;
  endtask

  task automatic test_present();
    bit seen = 1'b0;
    poll_left = 3;
    reads = 0;
    dones = 0;
    ea.push_back(64'h0200_0000_0000_0000);
    ed.push_back(64'h1);
    fork
      send_char(8'h51, 12'hABC);
      begin
        presentReq = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge procClock);
          if (busWrite) seen = 1'b1;
        end
        @(posedge procClock);
        #1;
        presentReq = 1'b0;
        for (int i = 0; i < 100 && dones == 0; i++) @(posedge procClock);
      end
    join
    wait_idle("present");
    n_tests++;
    if (wa_q.size() < 1 || wd_q[0] !== 64'h1) begin
      n_fail++;
      $display("FAIL present control: first write not 64'h1 (%0d writes logged)", wa_q.size());
    end
    n_tests++;
    if (reads !== 4) begin
      n_fail++;
      $display("FAIL present reads: got %0d required 4", reads);
    end
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL present done: got %0d pulses required 1", dones);
    end
    check_writes("present");
    check_cursor("present", m_col, m_row);
  endtask

  task automatic test_reset_mid_clear();
    send_char(8'h0C, 12'h0);
    repeat (200) @(posedge procClock);
    #1;
    resetN = 1'b0;
    #1;
    n_tests++;
    if ({busWrite, busRead, presentDone, charReady, busAddress, busDataOut, cursorCol,
         cursorRow} !== '0) begin
      n_fail++;
      $display("FAIL midreset outputs: got addr=%h data=%h wr=%b rdy=%b, required all zero",
               busAddress, busDataOut, busWrite, charReady);
    end
    wa_q.delete(); wd_q.delete(); ea.delete(); ed.delete();
    m_col = 0;
    m_row = 0;
    @(posedge procClock);
    #1;
    resetN = 1'b1;
    @(posedge procClock);
    #1;
    n_tests++;
    if (charReady !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset ready: got %b required 1", charReady);
    end
    send_char(8'h42, 12'h123);
    wait_idle("midreset");
    n_tests++;
    if (wa_q.size() !== 1 || wa_q[0] !== 64'h0200_0000_0000_0004 || wd_q[0] !== 64'h12342) begin
      n_fail++;
      $display("FAIL midreset put: got %0d writes, required one to offset 4 data 12342",
               wa_q.size());
    end
    check_writes("midreset");
    check_cursor("midreset", 1, 0);
  endtask

  initial begin
    resetN     = 1'b0;
    charData   = '0;
    charColour = '0;
    charValid  = 1'b0;
    presentReq = 1'b0;
    busGrant   = 1'b0;
    grant_mode = 0;
    poll_left  = 0;
    rd_seen    = 1'b0;
    m_col      = 0;
    m_row      = 0;
    test_reset();
    test_put_char();
    test_wrap_row();
    test_lf_wrap();
    test_clear_all();
    test_random();
    test_present();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
